// File: rtl/commit_arf_unit_pkg.sv
// Shared types for the commit/ARF retirement unit: FSM states, RAT entry layout, widths.
package commit_pkg;

    localparam int          REG_IDX_W          = 5;
    localparam int          TAG_W              = 4;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rat_entry_t;

endpackage

// File: rtl/commit_arf_unit_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 hardwired to zero.
module arf_regfile
    import commit_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // NOTE: every register-state update uses <= so all flops sample the same pre-edge values.
    // NOTE: the array is reset on purpose; architectural state must read zero after reset,
    //       so this stays a flop array rather than an inferred RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/commit_arf_unit.sv
// Retirement unit: ARF writeback, RAT busy tracking, exception flush walk and fetch redirect.
// Optional COMMIT_BYPASS_EN forwards a same-cycle normal commit onto the read ports.
module commit_arf_unit
    import commit_pkg::*;
#(
    parameter int          NUM_REGS   = 32,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 commit_valid,
    output logic                 commit_ready,
    input  logic [REG_IDX_W-1:0] commit_dest,
    input  logic [DATA_W-1:0]    commit_value,
    input  logic [TAG_W-1:0]     commit_tag,
    input  logic                 commit_except,
    input  logic [31:0]          commit_pc,
    input  logic                 ren_valid,
    input  logic [REG_IDX_W-1:0] ren_dest,
    input  logic [TAG_W-1:0]     ren_tag,
    input  logic [REG_IDX_W-1:0] rd_addr1,
    input  logic [REG_IDX_W-1:0] rd_addr2,
    output logic [DATA_W-1:0]    rd_val1,
    output logic [DATA_W-1:0]    rd_val2,
    output logic                 rd_busy1,
    output logic                 rd_busy2,
    output logic [TAG_W-1:0]     rd_tag1,
    output logic [TAG_W-1:0]     rd_tag2,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          epc
);

    state_t                 state, state_nxt;
    rat_entry_t             rat [NUM_REGS];
    logic [REG_IDX_W-1:0]   flush_cnt;
    logic [DATA_W-1:0]      arf_rd1, arf_rd2;
    logic                   commit_fire, commit_wr, commit_exc;

    assign commit_fire = (state == ST_RUN) && commit_valid;
    assign commit_exc  = commit_fire && commit_except;
    assign commit_wr   = commit_fire && !commit_except && (commit_dest != '0);

    arf_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_arf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (commit_wr),
        .waddr  (commit_dest),
        .wdata  (commit_value),
        .raddr1 (rd_addr1),
        .raddr2 (rd_addr2),
        .rdata1 (arf_rd1),
        .rdata2 (arf_rd2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:      if (commit_exc) state_nxt = ST_FLUSH;
            ST_FLUSH:    if (flush_cnt == REG_IDX_W'(NUM_REGS - 1)) state_nxt = ST_REDIRECT;
            ST_REDIRECT: state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        commit_ready   = (state == ST_RUN);
        flush          = (state == ST_FLUSH);
        redirect_valid = (state == ST_REDIRECT);
        redirect_pc    = redirect_valid ? HANDLER_PC : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            epc       <= '0;
        end else if (commit_exc) begin
            flush_cnt <= '0;
            epc       <= commit_pc;
        end else if (state == ST_FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // The rename update is written after the commit clear so a same-cycle rename wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rat[i] <= '0;
            end
        end else if (state == ST_FLUSH) begin
            rat[flush_cnt].busy <= 1'b0;
        end else if (state == ST_RUN) begin
            if (commit_wr && rat[commit_dest].busy && (rat[commit_dest].tag == commit_tag)) begin
                rat[commit_dest].busy <= 1'b0;
            end
            if (ren_valid && (ren_dest != '0)) begin
                rat[ren_dest] <= '{busy: 1'b1, tag: ren_tag};
            end
        end
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        rd_val1  = arf_rd1;
        rd_val2  = arf_rd2;
        rd_busy1 = (rd_addr1 != '0) && rat[rd_addr1].busy;
        rd_busy2 = (rd_addr2 != '0) && rat[rd_addr2].busy;
        rd_tag1  = rat[rd_addr1].tag;
        rd_tag2  = rat[rd_addr2].tag;
`ifdef COMMIT_BYPASS_EN
        if (commit_wr && (commit_dest == rd_addr1)) begin
            rd_val1 = commit_value;
            if (rat[rd_addr1].tag == commit_tag) rd_busy1 = 1'b0;
        end
        if (commit_wr && (commit_dest == rd_addr2)) begin
            rd_val2 = commit_value;
            if (rat[rd_addr2].tag == commit_tag) rd_busy2 = 1'b0;
        end
`else
`endif
    end

endmodule

// File: tb/tb_commit_arf_unit.sv
// Directed self-checking bench for commit_arf_unit: commit/rename, x0, flush walk, redirect, reset abort.
module tb_commit_arf_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid, commit_ready, commit_except;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value, commit_pc;
    logic [3:0]  commit_tag;
    logic        ren_valid;
    logic [4:0]  ren_dest;
    logic [3:0]  ren_tag;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_val1, rd_val2;
    logic        rd_busy1, rd_busy2;
    logic [3:0]  rd_tag1, rd_tag2;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc, epc;

    int n_checks = 0;
    int n_fail   = 0;

    commit_arf_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_dest    (commit_dest),
        .commit_value   (commit_value),
        .commit_tag     (commit_tag),
        .commit_except  (commit_except),
        .commit_pc      (commit_pc),
        .ren_valid      (ren_valid),
        .ren_dest       (ren_dest),
        .ren_tag        (ren_tag),
        .rd_addr1       (rd_addr1),
        .rd_addr2       (rd_addr2),
        .rd_val1        (rd_val1),
        .rd_val2        (rd_val2),
        .rd_busy1       (rd_busy1),
        .rd_busy2       (rd_busy2),
        .rd_tag1        (rd_tag1),
        .rd_tag2        (rd_tag2),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .epc            (epc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic do_ren(input logic [4:0] dest, input logic [3:0] tag);
        ren_valid = 1'b1; ren_dest = dest; ren_tag = tag;
        tick();
        ren_valid = 1'b0;
    endtask

    task automatic set_commit(input logic [4:0] dest, input logic [31:0] value, input logic [3:0] tag,
                              input logic exc, input logic [31:0] pc);
        commit_valid = 1'b1; commit_dest = dest; commit_value = value;
        commit_tag = tag; commit_except = exc; commit_pc = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        commit_valid = 0; commit_dest = 0; commit_value = 0; commit_tag = 0;
        commit_except = 0; commit_pc = 0;
        ren_valid = 0; ren_dest = 0; ren_tag = 0;
        rd_addr1 = 5'd5; rd_addr2 = 5'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("reset_rd_val1", rd_val1, 32'd0);
        check("reset_rd_busy1", {31'd0, rd_busy1}, 32'd0);
        check("reset_commit_ready", {31'd0, commit_ready}, 32'd1);
        check("reset_flush", {31'd0, flush}, 32'd0);
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset_epc", epc, 32'd0);

        // Rename r5 to tag 3, then retire it.
        do_ren(5'd5, 4'd3);
        check("r5_busy_after_ren", {31'd0, rd_busy1}, 32'd1);
        check("r5_tag_after_ren", {28'd0, rd_tag1}, 32'd3);
        set_commit(5'd5, 32'd128, 4'd3, 1'b0, 32'h0);
        tick();
        commit_valid = 1'b0;
        check("r5_val_after_commit", rd_val1, 32'd128);
        check("r5_busy_after_commit", {31'd0, rd_busy1}, 32'd0);

        // Older commit must not clear a younger rename of the same register.
        rd_addr2 = 5'd7;
        do_ren(5'd7, 4'd2);
        do_ren(5'd7, 4'd9);
        set_commit(5'd7, 32'd64, 4'd2, 1'b0, 32'h0);
        tick();
        commit_valid = 1'b0;
        check("r7_val", rd_val2, 32'd64);
        check("r7_busy_younger", {31'd0, rd_busy2}, 32'd1);
        check("r7_tag_younger", {28'd0, rd_tag2}, 32'd9);

        // Same-cycle rename and commit of r6: rename wins.
        rd_addr1 = 5'd6;
        do_ren(5'd6, 4'd1);
        set_commit(5'd6, 32'hAA, 4'd1, 1'b0, 32'h0);
        ren_valid = 1'b1; ren_dest = 5'd6; ren_tag = 4'd12;
        tick();
        commit_valid = 1'b0; ren_valid = 1'b0;
        check("r6_val_same_cycle", rd_val1, 32'hAA);
        check("r6_busy_same_cycle", {31'd0, rd_busy1}, 32'd1);
        check("r6_tag_same_cycle", {28'd0, rd_tag1}, 32'd12);

        // x0 is never written nor renamed.
        rd_addr1 = 5'd0;
        set_commit(5'd0, 32'd55, 4'd0, 1'b0, 32'h0);
        ren_valid = 1'b1; ren_dest = 5'd0; ren_tag = 4'd7;
        tick();
        commit_valid = 1'b0; ren_valid = 1'b0;
        check("r0_val", rd_val1, 32'd0);
        check("r0_busy", {31'd0, rd_busy1}, 32'd0);

        // Exception flush and redirect.
        rd_addr1 = 5'd3; rd_addr2 = 5'd4;
        do_ren(5'd3, 4'd4);
        do_ren(5'd4, 4'd5);
        check("r3_busy_pre_exc", {31'd0, rd_busy1}, 32'd1);
        check("r4_busy_pre_exc", {31'd0, rd_busy2}, 32'd1);
        set_commit(5'd9, 32'h77, 4'd7, 1'b1, 32'h40);
        tick();
        // Keep presenting a commit and a rename early in FLUSH; both must be ignored.
        set_commit(5'd9, 32'h99, 4'd8, 1'b0, 32'h0);
        ren_valid = 1'b1; ren_dest = 5'd10; ren_tag = 4'd3;
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                commit_valid = 1'b0; ren_valid = 1'b0;
            end
            check($sformatf("flush_hi_c%0d", i), {31'd0, flush}, 32'd1);
            check($sformatf("flush_ready_lo_c%0d", i), {31'd0, commit_ready}, 32'd0);
            check($sformatf("flush_no_redirect_c%0d", i), {31'd0, redirect_valid}, 32'd0);
            tick();
        end
        check("redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("redirect_pc", redirect_pc, 32'h100);
        check("redirect_flush_lo", {31'd0, flush}, 32'd0);
        check("redirect_ready_lo", {31'd0, commit_ready}, 32'd0);
        check("epc_after_exc", epc, 32'h40);
        tick();
        check("post_redirect_valid_lo", {31'd0, redirect_valid}, 32'd0);
        check("post_redirect_pc_zero", redirect_pc, 32'd0);
        check("post_redirect_ready", {31'd0, commit_ready}, 32'd1);
        check("r3_busy_post_flush", {31'd0, rd_busy1}, 32'd0);
        check("r4_busy_post_flush", {31'd0, rd_busy2}, 32'd0);
        rd_addr1 = 5'd9; rd_addr2 = 5'd10;
        #1;
        check("r9_no_write_exc", rd_val1, 32'd0);
        check("r10_ren_ignored", {31'd0, rd_busy2}, 32'd0);
        rd_addr1 = 5'd7; rd_addr2 = 5'd5;
        #1;
        check("r7_busy_cleared_flush", {31'd0, rd_busy1}, 32'd0);
        check("r5_val_kept", rd_val2, 32'd128);

        // Reset during cycle 10 of FLUSH aborts to RUN with no redirect.
        rd_addr1 = 5'd8;
        do_ren(5'd8, 4'd2);
        set_commit(5'd11, 32'h5, 4'd2, 1'b1, 32'h80);
        tick();
        commit_valid = 1'b0;
        check("epc_second_exc", epc, 32'h80);
        for (int i = 0; i < 9; i++) tick();
        check("flush_hi_cycle10", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_abort_flush_lo", {31'd0, flush}, 32'd0);
        check("rst_abort_ready", {31'd0, commit_ready}, 32'd1);
        check("rst_abort_epc", epc, 32'd0);
        check("rst_abort_r8_busy", {31'd0, rd_busy1}, 32'd0);
        check("rst_abort_arf_r5", rd_val2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_abort_no_redirect_%0d", i), {31'd0, redirect_valid}, 32'd0);
            tick();
        end
        rd_addr1 = 5'd2;
        set_commit(5'd2, 32'd5, 4'd0, 1'b0, 32'h0);
        tick();
        commit_valid = 1'b0;
        check("commit_after_rst_abort", rd_val1, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
